// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for the MIPS EX stage.
// Mul uses 32 shift-add steps and div uses 32 restoring steps, both on magnitudes; a FIX cycle applies the signs.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  // Request handshake: start is a single-cycle request sampled with op/a/b on a rising edge.
  // It is honoured only when busy is low. done pulses for one cycle once HI/LO hold a mul/div result.

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Even op codes among the mul/div group are the signed variants.
  assign a_neg = ~op[0] & a[31];
  assign b_neg = ~op[0] & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = acc_q[63:31];
  assign div_trial = div_shift - {1'b0, opnd_q};

  assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  // Divide-by-zero yields all-ones quotient; remainder restores to the original dividend.
  assign quo_fix  = div0_q ? 32'hFFFF_FFFF
                  : (neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0]);
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_d     = {32'd0, b_mag};
              opnd_d    = a_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = 5'd0;
              state_d   = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              acc_d     = {32'd0, a_mag};
              opnd_d    = b_mag;
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              div0_d    = (b == 32'd0);
              is_div_d  = 1'b1;
              cnt_d     = 5'd0;
              state_d   = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_trial[32]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
        else                acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit; the expected {hi,lo} for each accepted mul/div is queued and checked on done.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  logic        clk, rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        prev_done = 1'b0;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic, result is {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, m;
    longint unsigned ux, uy, uq, um;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = 64'd0;
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = ux * uy;
      OP_DIV: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else begin
          uq = ux / uy;
          um = ux % uy;
          r  = {um[31:0], uq[31:0]};
        end
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // driver tasks: called at a negedge; the next posedge samples the request
  task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = OP_NOP;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_q.push_back(model(o, x, y));
    drive(o, x, y);
  endtask

  task automatic wait_done(input bit chk_lat);
    int n = 0;
    int busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end else if (chk_lat) begin
      check("latency", 64'(n), 64'd33);
      check("busy_cycles", 64'(busy_cnt), 64'd33);
      check("busy_at_done", {63'd0, busy}, 64'd0);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse_width", {63'd0, prev_done}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
    prev_done = done;
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] hl;
    rst = 1'b1; start = 1'b0; op = OP_NOP; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_state", {59'd0, busy, done, dbg_state, 1'b0}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed test-plan cases
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_done(1);
    check("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done(1);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done(1);
    check("mult_m1xm1", {hi, lo}, 64'h0000_0000_0000_0001);
    issue(OP_DIVU, 32'd100, 32'd7);                wait_done(1);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);           wait_done(1);
    check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);           wait_done(1);
    check("div_7_m2", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done(1);
    check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
    issue(OP_DIVU, 32'd123, 32'd0);                wait_done(1);
    check("divu_by_zero", {hi, lo}, {32'd123, 32'hFFFF_FFFF});
    issue(OP_DIV, 32'hFFFF_FF85, 32'd0);           wait_done(1);
    check("div_by_zero_neg", {hi, lo}, {32'hFFFF_FF85, 32'hFFFF_FFFF});

    // starts while busy are ignored
    issue(OP_MULT, 32'd3, 32'd9);
    repeat (9) @(negedge clk);
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    drive(OP_MULTU, 32'd1, 32'd1);
    wait_done(0);
    check("busy_ignore_mthi", {hi, lo}, {32'd0, 32'd27});

    // MT ops and no-ops in IDLE
    @(negedge clk);
    drive(OP_MTLO, 32'h0000_1234, 32'd0);
    check("mtlo", {hi, lo}, {32'd0, 32'h0000_1234});
    check("mtlo_no_busy", {62'd0, busy, done}, 64'd0);
    drive(OP_MTHI, 32'hCAFE_F00D, 32'd0);
    check("mthi", {hi, lo}, {32'hCAFE_F00D, 32'h0000_1234});
    drive(OP_NOP, 32'h1111_1111, 32'd0);
    drive(3'b111, 32'h2222_2222, 32'd0);
    check("nop_ops", {hi, lo, 31'd0, busy}, {32'hCAFE_F00D, 32'h0000_1234, 32'd0});

    // back-to-back start on the done cycle
    issue(OP_MULTU, 32'd1000, 32'd1000); wait_done(1);
    issue(OP_DIVU, 32'd1000, 32'd33);    wait_done(1);
    issue(OP_MULT, 32'hFFFF_0000, 32'h0001_0000); wait_done(1);

    // reset during a DIVU aborts it
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_reset", {hi, lo, 30'd0, busy, done}, 96'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(OP_MULTU, 32'd6, 32'd7); wait_done(1);
    check("multu_6x7_after_reset", {hi, lo}, 64'd42);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      issue(ro, ra, rb);
      wait_done(i % 8 == 0);
      if (i % 5 == 0) begin
        hl = {hi, lo};
        ra = $urandom;
        if (i % 2 == 0) begin
          drive(OP_MTHI, ra, 32'd0);
          check("rand_mthi", {hi, lo}, {ra, hl[31:0]});
        end else begin
          drive(OP_MTLO, ra, 32'd0);
          check("rand_mtlo", {hi, lo}, {hl[63:32], ra});
        end
      end
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
